// File: rtl/seg7_pkg.sv
// seg7_reader shared types: segment codes, FSM states, decode helper.
// SEG7_BLANK_EN makes the all-off pattern a legal (blank) code.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  // Active-low patterns, bit i = segment i (0 top ... 6 middle).
  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b0000011;
  localparam seg_t SEG_C = 7'b1000110;
  localparam seg_t SEG_D = 7'b0100001;
  localparam seg_t SEG_E = 7'b0000110;
  localparam seg_t SEG_F = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_e;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] digit;
  } dec_t;

  function automatic dec_t seg7_decode(input seg_t s);
    dec_t r;
    r = '{legal: 1'b1, blank: 1'b0, digit: 4'h0};
    unique case (s)
      SEG_0: r.digit = 4'h0;
      SEG_1: r.digit = 4'h1;
      SEG_2: r.digit = 4'h2;
      SEG_3: r.digit = 4'h3;
      SEG_4: r.digit = 4'h4;
      SEG_5: r.digit = 4'h5;
      SEG_6: r.digit = 4'h6;
      SEG_7: r.digit = 4'h7;
      SEG_8: r.digit = 4'h8;
      SEG_9: r.digit = 4'h9;
      SEG_A: r.digit = 4'hA;
      SEG_B: r.digit = 4'hB;
      SEG_C: r.digit = 4'hC;
      SEG_D: r.digit = 4'hD;
      SEG_E: r.digit = 4'hE;
      SEG_F: r.digit = 4'hF;
`ifdef SEG7_BLANK_EN
      SEG_BLANK: r.blank = 1'b1;
`endif
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_reader_sync.sv
// Two-flop synchronizer for the 7-bit segment bus, resets to all-off.
// Ports: clk, reset (async high), d (async in), q (synchronized out).
module seg7_sync
  import seg7_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  seg_t d,
  output seg_t q
);

  seg_t meta_q;
  seg_t sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= SEG_BLANK;
      sync_q <= SEG_BLANK;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/seg7_reader.sv
// Active-low 7-segment pattern reader: sync, debounce, decode, 1-entry out.
// Ports: clk, reset, segments in; out_data/out_blank/out_valid/out_ready
// handshake; locked, bad_pattern, overrun status. Macro: SEG7_BLANK_EN.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] segments,
  output logic [3:0] out_data,
  output logic       out_blank,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       locked,
  output logic       bad_pattern,
  output logic       overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  seg_t seg_s;
  seg_t seg_p_q, seg_p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e state_q, state_d;
  logic [3:0] out_data_q, out_data_d;
  logic out_blank_q, out_blank_d;
  logic out_valid_q, out_valid_d;
  logic bad_q, bad_d;
  logic ovr_q, ovr_d;

  logic diff;
  logic accept;
  logic result;
  logic hs;
  logic load;
  dec_t dec;

  seg7_sync u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (segments),
    .q    (seg_s)
  );

  always_comb begin
    diff    = (seg_s != seg_p_q);
    seg_p_d = seg_s;
    cnt_d   = cnt_q;
    if (diff) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // cnt_q counts equal samples ending in seg_p_q, so decode that value.
    dec    = seg7_decode(seg_p_q);
    accept = (state_q == SETTLE) && (cnt_q == CNT_MAX);

    state_d = state_q;
    unique case (state_q)
      SETTLE: if (accept && !diff) state_d = LOCKED;
      LOCKED: if (diff) state_d = SETTLE;
      default: state_d = SETTLE;
    endcase

    result = accept && dec.legal;
    bad_d  = accept && !dec.legal;
    hs     = out_valid_q && out_ready;
    load   = result && (!out_valid_q || out_ready);
    ovr_d  = result && out_valid_q && !out_ready;

    out_data_d  = out_data_q;
    out_blank_d = out_blank_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_data_d  = dec.digit;
      out_blank_d = dec.blank;
      out_valid_d = 1'b1;
    end else if (hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_p_q     <= SEG_BLANK;
      cnt_q       <= '0;
      state_q     <= SETTLE;
      out_data_q  <= 4'h0;
      out_blank_q <= 1'b0;
      out_valid_q <= 1'b0;
      bad_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      seg_p_q     <= seg_p_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_blank_q <= out_blank_d;
      out_valid_q <= out_valid_d;
      bad_q       <= bad_d;
      ovr_q       <= ovr_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_blank   = out_blank_q;
  assign out_valid   = out_valid_q;
  assign locked      = (state_q == LOCKED);
  assign bad_pattern = bad_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader (STABLE_CYCLES = 4).
// Reference: digit table lookup and pattern-change event model.
module tb_seg7_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] segments = 7'b1000000;
  logic [3:0] out_data;
  logic       out_blank;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       locked;
  logic       bad_pattern;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  int bad_cnt = 0;
  int ovr_cnt = 0;
  int got[$];

  logic [6:0] codes [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg7_reader #(.STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .segments   (segments),
    .out_data   (out_data),
    .out_blank  (out_blank),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .locked     (locked),
    .bad_pattern(bad_pattern),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bad_pattern) bad_cnt++;
    if (overrun) ovr_cnt++;
    if (out_valid && out_ready) got.push_back(int'(out_data));
  end

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (codes[i] == p) return i;
    return -1;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(2);
    chk("rst_data", int'(out_data), 0);
    chk("rst_blank", int'(out_blank), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_bad", int'(bad_pattern), 0);
    chk("rst_ovr", int'(overrun), 0);
  endtask

  task automatic test_basic;
    segments = codes[2];
    reset = 1'b0;
    step(6);
    chk("basic_early_valid", int'(out_valid), 0);
    chk("basic_early_locked", int'(locked), 0);
    step(1);
    chk("basic_valid", int'(out_valid), 1);
    chk("basic_data", int'(out_data), 2);
    chk("basic_locked", int'(locked), 1);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("basic_consumed", int'(out_valid), 0);
  endtask

  task automatic test_bad;
    int b0;
    b0 = bad_cnt;
    segments = 7'b1010101;
    step(6);
    chk("bad_early", int'(bad_pattern), 0);
    step(1);
    chk("bad_pulse", int'(bad_pattern), 1);
    chk("bad_novalid", int'(out_valid), 0);
    step(1);
    chk("bad_onewide", int'(bad_pattern), 0);
    step(3);
    chk("bad_count", bad_cnt - b0, 1);
  endtask

  task automatic test_blank;
    int b0;
    b0 = bad_cnt;
    segments = 7'b1111111;
    step(7);
`ifdef SEG7_BLANK_EN
    chk("blank_valid", int'(out_valid), 1);
    chk("blank_flag", int'(out_blank), 1);
    chk("blank_data", int'(out_data), 0);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("blank_nobad", bad_cnt - b0, 0);
`else
    chk("blank_bad", int'(bad_pattern), 1);
    chk("blank_novalid", int'(out_valid), 0);
    chk("blank_tied", int'(out_blank), 0);
`endif
    step(3);
  endtask

  task automatic test_sweep;
    int b0, o0;
    b0 = bad_cnt;
    o0 = ovr_cnt;
    got.delete();
    out_ready = 1'b1;
    for (int d = 0; d < 16; d++) begin
      segments = codes[d];
      step(10);
    end
    out_ready = 1'b0;
    chk("sweep_count", got.size(), 16);
    for (int d = 0; d < 16 && d < got.size(); d++)
      chk($sformatf("sweep_digit%0d", d), got[d], d);
    chk("sweep_nobad", bad_cnt - b0, 0);
    chk("sweep_noovr", ovr_cnt - o0, 0);
    chk("sweep_blank", int'(out_blank), 0);
  endtask

  task automatic test_random;
    int exp_q[$];
    int exp_bad;
    int b0, o0, idx, mism;
    logic [6:0] prev, p;
    b0 = bad_cnt;
    o0 = ovr_cnt;
    exp_bad = 0;
    got.delete();
    prev = segments;
    out_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        do p = 7'($urandom);
        while (lookup(p) >= 0 || p == 7'h7f);
      end else begin
        p = codes[$urandom_range(0, 15)];
      end
      // A held pattern yields an event only when it differs from the last.
      if (p != prev) begin
        idx = lookup(p);
        if (idx >= 0) exp_q.push_back(idx);
        else exp_bad++;
      end
      prev = p;
      segments = p;
      step($urandom_range(8, 12));
    end
    out_ready = 1'b0;
    chk("rand_count", got.size(), exp_q.size());
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      if (got[i] != exp_q[i]) mism++;
    chk("rand_digits", mism, 0);
    chk("rand_bad", bad_cnt - b0, exp_bad);
    chk("rand_noovr", ovr_cnt - o0, 0);
  endtask

  task automatic test_glitch;
    int b0, ones, dchg;
    out_ready = 1'b1;
    segments = codes[0];
    step(12);
    b0 = bad_cnt;
    got.delete();
    dchg = 0;
    segments = codes[1];
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (out_data != 4'h0) dchg++;
    end
    segments = codes[0];
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (out_data != 4'h0) dchg++;
    end
    out_ready = 1'b0;
    ones = 0;
    foreach (got[i]) if (got[i] == 1) ones++;
    chk("glitch_no_one", ones, 0);
    chk("glitch_data_held", dchg, 0);
    chk("glitch_nobad", bad_cnt - b0, 0);
  endtask

  task automatic test_overrun;
    int o0;
    out_ready = 1'b0;
    o0 = ovr_cnt;
    segments = codes[5];
    step(10);
    chk("ovr_first", int'(out_data), 5);
    segments = codes[7];
    step(10);
    chk("ovr_held_data", int'(out_data), 5);
    chk("ovr_held_valid", int'(out_valid), 1);
    chk("ovr_pulses", ovr_cnt - o0, 1);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("ovr_drained", int'(out_valid), 0);
    o0 = ovr_cnt;
    segments = codes[5];
    step(10);
    chk("ovr2_first", int'(out_data), 5);
    segments = codes[7];
    step(6);
    out_ready = 1'b1;
    step(1);
    chk("ovr2_data", int'(out_data), 7);
    chk("ovr2_valid", int'(out_valid), 1);
    chk("ovr2_noflag", int'(overrun), 0);
    out_ready = 1'b0;
    step(2);
    chk("ovr2_nopulse", ovr_cnt - o0, 0);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    segments = codes[3];
    step(8);
    chk("mid_locked", int'(locked), 1);
    chk("mid_valid", int'(out_valid), 1);
    chk("mid_data", int'(out_data), 3);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_data", int'(out_data), 0);
    step(1);
    reset = 1'b0;
    step(6);
    chk("mid_relock_early", int'(locked), 0);
    step(1);
    chk("mid_relock", int'(locked), 1);
    chk("mid_revalid", int'(out_valid), 1);
    chk("mid_redata", int'(out_data), 3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad();
    test_blank();
    test_sweep();
    test_random();
    test_glitch();
    test_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
